// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Works on operand magnitudes one bit per cycle, then applies the sign fix in a final cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             HiWrEn,
    input  logic             LoWrEn,
    input  logic [WIDTH-1:0] WrData,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       dbg_state_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      count_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   acc_hi_q, acc_lo_q, opnd_q;
    logic [WIDTH-1:0]   acc_hi_d, acc_lo_d;
    logic               is_div_q, neg_lo_q, neg_hi_q, div0_q;

    logic               in_signed, in_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign in_signed = ~Op[0];
    assign in_div    = Op[1];
    assign a_neg     = in_signed & SrcA[WIDTH-1];
    assign b_neg     = in_signed & SrcB[WIDTH-1];
    assign a_mag     = a_neg ? -SrcA : SrcA;
    assign b_mag     = b_neg ? -SrcB : SrcB;

    // acc_lo holds the multiplier (shifted out right) or the dividend (shifted out left,
    // quotient bits shifted in). opnd holds the multiplicand or the divisor.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        acc_hi_d  = mul_sum[WIDTH:1];
        acc_lo_d  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                acc_hi_d = div_diff[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_d = div_shift[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Divide by zero leaves the full dividend magnitude as remainder, so the normal
    // remainder sign fix already reproduces SrcA; only the quotient needs forcing.
    always_comb begin
        prod     = {acc_hi_q, acc_lo_q};
        prod_fix = neg_lo_q ? -prod : prod;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            fix_hi = neg_hi_q ? -acc_hi_q : acc_hi_q;
            fix_lo = div0_q ? '1 : (neg_lo_q ? -acc_lo_q : acc_lo_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (HiWrEn) hi_q <= WrData;
                    if (LoWrEn) lo_q <= WrData;
                    if (Start) begin
                        state_q  <= S_CALC;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        acc_hi_q <= '0;
                        acc_lo_q <= in_div ? a_mag : b_mag;
                        opnd_q   <= in_div ? b_mag : a_mag;
                        is_div_q <= in_div;
                        neg_lo_q <= a_neg ^ b_neg;
                        neg_hi_q <= a_neg;
                        div0_q   <= in_div & (SrcB == '0);
                    end
                end
                S_CALC: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    count_q  <= count_q + 1'b1;
                    if (count_q == LAST) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Hi          = hi_q;
    assign Lo          = lo_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] SrcA, SrcB, WrData;
    logic         HiWrEn, LoWrEn;
    logic [W-1:0] Hi, Lo;
    logic         Busy, Done;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_hi, exp_lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
        .HiWrEn(HiWrEn), .LoWrEn(LoWrEn), .WrData(WrData),
        .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Reference: 64-bit arithmetic; SV division truncates toward zero and % follows the dividend.
    function automatic void ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
            2'd1: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
            2'd2: begin
                if (b == '0) begin hi = a; lo = '1; end
                else begin sq = sa / sb; sr = sa % sb; hi = sr[31:0]; lo = sq[31:0]; end
            end
            default: begin
                if (b == '0) begin hi = a; lo = '1; end
                else begin uq = ua / ub; ur = ua % ub; hi = ur[31:0]; lo = uq[31:0]; end
            end
        endcase
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Called away from the clock edge; returns #1 after the edge where Done rises.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit disturb, input bit mt_start, input string tag);
        logic [W-1:0] rh, rl, old_hi, old_lo, w;
        int lat;
        bit seen;
        ref_op(op, a, b, rh, rl);
        Start = 1'b1; Op = op; SrcA = a; SrcB = b;
        if (mt_start) begin
            w = $urandom;
            HiWrEn = 1'b1; WrData = w; exp_hi = w;
        end
        @(posedge clk); #1;
        Start = 1'b0; HiWrEn = 1'b0;
        Op = 2'($urandom); SrcA = $urandom; SrcB = $urandom; WrData = $urandom;
        chk1({tag, " busy_rise"}, Busy, 1'b1);
        chk1({tag, " done_low"}, Done, 1'b0);
        if (mt_start) chk32({tag, " mthi_with_start"}, Hi, exp_hi);
        old_hi = exp_hi;
        old_lo = exp_lo;
        lat = 0;
        seen = 0;
        while (!seen && lat < W + 8) begin
            if (disturb && lat == 4) begin
                Start = 1'b1; HiWrEn = 1'b1; LoWrEn = 1'b1; WrData = ~rh;
            end
            @(posedge clk); #1;
            lat++;
            Start = 1'b0; HiWrEn = 1'b0; LoWrEn = 1'b0;
            if (Done) seen = 1;
            else if (lat == W / 2) begin
                chk32({tag, " hold_hi"}, Hi, old_hi);
                chk32({tag, " hold_lo"}, Lo, old_lo);
                chk1({tag, " busy_mid"}, Busy, 1'b1);
            end
        end
        chk32({tag, " latency"}, lat, W + 1);
        exp_hi = rh;
        exp_lo = rl;
        chk32({tag, " hi"}, Hi, exp_hi);
        chk32({tag, " lo"}, Lo, exp_lo);
        chk1({tag, " busy_fall"}, Busy, 1'b0);
    endtask

    task automatic mt_write(input bit wh, input bit wl, input logic [W-1:0] d, input string tag);
        HiWrEn = wh; LoWrEn = wl; WrData = d;
        @(posedge clk); #1;
        HiWrEn = 1'b0; LoWrEn = 1'b0; WrData = $urandom;
        if (wh) exp_hi = d;
        if (wl) exp_lo = d;
        chk32({tag, " hi"}, Hi, exp_hi);
        chk32({tag, " lo"}, Lo, exp_lo);
    endtask

    initial begin
        rst = 1'b0; Start = 1'b0; Op = '0; SrcA = '0; SrcB = '0;
        HiWrEn = 1'b0; LoWrEn = 1'b0; WrData = '0;
        exp_hi = '0; exp_lo = '0;
        repeat (3) @(posedge clk);
        #1;
        chk32("reset hi", Hi, '0);
        chk32("reset lo", Lo, '0);
        chk1("reset busy", Busy, 1'b0);
        chk1("reset done", Done, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
        @(posedge clk); #1;
        chk1("multu_max done_once", Done, 1'b0);
        do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0, 0, "mult_neg");
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_neg");
        do_op(2'd3, 32'd100, 32'd7, 0, 0, "divu_100_7");
        do_op(2'd2, 32'h1234_5678, 32'd0, 0, 0, "div_by_zero");
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_overflow");
        do_op(2'd3, 32'h8765_4321, 32'd0, 0, 0, "divu_by_zero");
        do_op(2'd2, 32'h8000_0000, 32'd0, 0, 0, "div_minint_by_zero");

        do_op(2'd0, 32'd1234, 32'hFFFF_FFF7, 1, 0, "busy_ignore");
        @(posedge clk); #1;
        chk1("no_queued_start busy", Busy, 1'b0);
        chk1("no_queued_start done", Done, 1'b0);
        mt_write(0, 1, 32'hA5A5_A5A5, "mtlo_idle");
        mt_write(1, 0, $urandom, "mthi_idle");
        mt_write(1, 1, $urandom, "mthi_mtlo_idle");
        do_op(2'd1, $urandom, $urandom, 0, 1, "mt_with_start");
        @(posedge clk); #1;

        Start = 1'b1; Op = 2'd0; SrcA = 32'h0BAD_F00D; SrcB = 32'hFFFF_0003;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        exp_hi = '0; exp_lo = '0;
        chk32("async_rst hi", Hi, '0);
        chk32("async_rst lo", Lo, '0);
        chk1("async_rst busy", Busy, 1'b0);
        chk1("async_rst done", Done, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk1("in_rst no_done", Done, 1'b0);
        end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (Done || Busy) chk1("after_rst idle", Done | Busy, 1'b0);
        end
        chk1("after_rst busy", Busy, 1'b0);
        do_op(2'd1, 32'd3, 32'd5, 0, 0, "multu_3x5");

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
                chk1("rand idle done_low", Done, 1'b0);
                if ($urandom_range(0, 2) == 0)
                    mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, "rand_mt");
            end
            do_op(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 3) == 0), "rand_op");
        end
        @(posedge clk); #1;
        chk1("final done_low", Done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
